regfile_writeback: RTL

- Producer-side front end for the 32x32 register file write port (clk, rd[31:0], wr_en, result[31:0]).
- Merges two result sources into one registered write per cycle:
  - single-cycle ALU results, which cannot be back-pressured;
  - long-latency load/multi-cycle results, which use a valid/ready handshake and a small FIFO.
- Keeps a pending-write scoreboard so decode can hold instructions whose source registers are not yet written.

---
 rtl/regfile_writeback.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// Register-file write-port front end: merges ALU and long-latency results and tracks pending writes.
// Optional same-cycle bypass ports are built when REGFILE_WB_BYPASS_EN is defined.
module regfile_writeback #(
   parameter int LSU_DEPTH    = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_result,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic [4:0]  lsu_rd,
   input  logic [31:0] lsu_result,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic        wr_en,
   output logic [31:0] rd,
   output logic [31:0] result,
   output logic [31:0] pending,
`ifdef REGFILE_WB_BYPASS_EN
   input  logic [4:0]  byp_rs1,
   input  logic [4:0]  byp_rs2,
   output logic        byp1_hit,
   output logic [31:0] byp1_value,
   output logic        byp2_hit,
   output logic [31:0] byp2_value,
`endif
   output logic        alu_stall
);

   localparam int PTR_W = $clog2(LSU_DEPTH);
   localparam int CNT_W = $clog2(LSU_DEPTH + 1);
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LSU_DEPTH);
   localparam logic [STV_W-1:0] LIMIT_C = STV_W'(STARVE_LIMIT);

   logic [36:0]      r_mem [LSU_DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic [STV_W-1:0] r_starve;
   logic             r_wr_en;
   logic [4:0]       r_rd;
   logic [31:0]      r_result;
   logic [31:0]      r_pending;

   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic [4:0]       w_head_rd;
   logic [31:0]      w_head_result;
   logic [4:0]       w_sel_rd;
   logic [31:0]      w_sel_result;
   logic             w_sel_we;
   logic [31:0]      w_pend_nxt;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == DEPTH_C);
   assign lsu_ready = ~w_full;
   assign w_push    = lsu_valid & ~w_full;
   // ALU results cannot be held off, so the FIFO only drains on ALU-idle cycles.
   assign w_pop     = ~alu_valid & ~w_empty;
   assign {w_head_rd, w_head_result} = r_mem[r_rptr];

   always_comb begin
      w_sel_rd     = w_head_rd;
      w_sel_result = w_head_result;
      if (alu_valid) begin
         w_sel_rd     = alu_rd;
         w_sel_result = alu_result;
      end
      w_sel_we = (alu_valid | w_pop) && (w_sel_rd != 5'd0);
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= {lsu_rd, lsu_result};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if (w_empty || w_pop) begin
         r_starve <= '0;
      end else if (alu_valid && (r_starve != LIMIT_C)) begin
         r_starve <= r_starve + 1'b1;
      end
   end

   assign alu_stall = (r_starve == LIMIT_C);

   // Set is applied after clear so a re-issue to the same register stays pending.
   always_comb begin
      w_pend_nxt = r_pending;
      if (w_pop && (w_head_rd != 5'd0)) w_pend_nxt[w_head_rd] = 1'b0;
      if (issue_valid && (issue_rd != 5'd0)) w_pend_nxt[issue_rd] = 1'b1;
      w_pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_en   <= 1'b0;
         r_rd      <= '0;
         r_result  <= '0;
         r_pending <= '0;
      end else begin
         r_wr_en   <= w_sel_we;
         r_pending <= w_pend_nxt;
         if (w_sel_we) begin
            r_rd     <= w_sel_rd;
            r_result <= w_sel_result;
         end
      end
   end

   assign wr_en   = r_wr_en;
   assign rd      = {27'd0, r_rd};
   assign result  = r_result;
   assign pending = r_pending;

`ifdef REGFILE_WB_BYPASS_EN
   assign byp1_hit   = r_wr_en && (r_rd == byp_rs1) && (byp_rs1 != 5'd0);
   assign byp2_hit   = r_wr_en && (r_rd == byp_rs2) && (byp_rs2 != 5'd0);
   assign byp1_value = byp1_hit ? r_result : 32'd0;
   assign byp2_value = byp2_hit ? r_result : 32'd0;
`endif

endmodule
